mem_arbiter: RTL

//  Shares the single data-memory port (read/write/addr/d_in/d_out) between N requesters.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port data memory between REQ_COUNT requesters (index 0 = CPU).
// Round-robin arbitration with optional CPU priority bounded by a starvation counter.
module mem_arbiter #(
  parameter int REQ_COUNT    = 4,
  parameter int DATA_W       = 16,
  parameter int CPU_PRIO     = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REQ_COUNT-1:0] req,
  input  logic [REQ_COUNT-1:0] we,
  input  logic [DATA_W-1:0]    addr  [0:REQ_COUNT-1],
  input  logic [DATA_W-1:0]    wdata [0:REQ_COUNT-1],
  output logic [REQ_COUNT-1:0] gnt,
  output logic [REQ_COUNT-1:0] ack,
  output logic [DATA_W-1:0]    rdata,
  output logic                 busy,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_d_in,
  input  logic [DATA_W-1:0]    mem_d_out
);

  localparam int IDX_W = $clog2(REQ_COUNT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [3:0]          starve_q, starve_d;

  logic                cpu_masked;
  logic                others_req;
  logic                rr_found;
  logic [IDX_W-1:0]    rr_win;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W:0]      rr_idx;
  logic [REQ_COUNT-1:0] cand;

  assign cpu_masked = (CPU_PRIO != 0) && (starve_q == 4'(STARVE_LIMIT));
  assign others_req = |req[REQ_COUNT-1:1];

  // Round-robin scan starts just after the last winner; the extra index bit absorbs the wrap.
  always_comb begin : arbitrate
    cand = req;
    if (cpu_masked) cand[0] = 1'b0;
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = '0;
    for (int i = 1; i <= REQ_COUNT; i++) begin
      rr_idx = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (rr_idx >= (IDX_W+1)'(REQ_COUNT)) rr_idx = rr_idx - (IDX_W+1)'(REQ_COUNT);
      if (!rr_found && cand[rr_idx[IDX_W-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[IDX_W-1:0];
      end
    end
    if ((CPU_PRIO != 0) && req[0] && !cpu_masked) winner = '0;
    else if (rr_found)                             winner = rr_win;
    else                                           winner = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_q     <= IDX_W'(REQ_COUNT-1);
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ISSUE;
          owner_d = winner;
          rr_d    = winner;
          we_d    = we[winner];
          addr_d  = addr[winner];
          wdata_d = wdata[winner];
          if (CPU_PRIO != 0) begin
            if (winner == '0) begin
              if (others_req && (starve_q < 4'(STARVE_LIMIT))) starve_d = starve_q + 4'd1;
            end else begin
              starve_d = '0;
            end
          end
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (!we_q) rdata_d = mem_d_out;
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    busy      = (state_q != S_IDLE);
    mem_read  = (state_q == S_ISSUE) && !we_q;
    mem_write = (state_q == S_ISSUE) && we_q;
    mem_addr  = (state_q == S_ISSUE) ? addr_q : '0;
    mem_d_in  = ((state_q == S_ISSUE) && we_q) ? wdata_q : '0;
    rdata     = rdata_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < REQ_COUNT; gi++) begin : g_owner
      assign gnt[gi] = (state_q != S_IDLE) && (owner_q == IDX_W'(gi));
      assign ack[gi] = (state_q == S_ACK)  && (owner_q == IDX_W'(gi));
    end
  endgenerate

endmodule
